dmux_route_ctrl: RTL and testbench
==================================

Name: dmux_route_ctrl

Overview:
- Sequencing controller for the 1-to-2 data demultiplexer.
- Accepts a valid/ready input word stream and holds each word in a data register that drives the demux data input.
- Drives the demux select and a valid/ready handshake on each of the two output branches.
- Routing is tag-directed (per-word destination bit) or alternating bursts of BURST words; saturating per-branch transfer counters are kept for debug.

Parameters:
- A, 8, data width of the routed word; matches the demux data width.
- BURST, 4, words sent to one branch before switching in alternate mode; legal range 1..255.
- CW, 8, width of the per-branch transfer counters.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  A  word to route.
- in_valid  input  1  in_data valid.
- in_dest  input  1  destination in tag mode: 1 = branch 1, 0 = branch 2.
- in_ready  output  1  controller can accept a word this cycle.
- mode  input  1  0 = tag-directed, 1 = alternating bursts; sampled per accepted word.
- cnt_clr  input  1  synchronous clear of cnt1/cnt2.
- dmux_a  output  A  held word, drives the demux data input.
- dmux_sel  output  1  demux select: 1 = branch 1, 0 = branch 2.
- out1_valid  output  1  branch 1 holds a valid word.
- out1_ready  input  1  branch 1 consumer accepts.
- out2_valid  output  1  branch 2 holds a valid word.
- out2_ready  input  1  branch 2 consumer accepts.
- cnt1  output  CW  words delivered to branch 1, saturating.
- cnt2  output  CW  words delivered to branch 2, saturating.
- busy  output  1  high while in HOLD.

Behaviour:
- Reset values: state IDLE; dmux_a = 0; dmux_sel = 0; out1_valid = out2_valid = 0; cnt1 = cnt2 = 0; busy = 0; rr_sel = 1; bcnt = 0.
- Reset is asynchronous and takes effect mid-transfer. The held word is dropped and no counter increments.
- FSM states:
  - IDLE: nothing held; in_ready = 1.
  - HOLD: one word held in dmux_a.
- Outputs by state:
  - out1_valid = HOLD & dmux_sel.
  - out2_valid = HOLD & ~dmux_sel.
  - busy = HOLD.
- Delivery: del = HOLD & (dmux_sel ? out1_ready : out2_ready).
- in_ready = IDLE | del. This is combinational and allows back-to-back words at 1 word/clk.
- Accept: acc = in_valid & in_ready. On acc, dmux_a <= in_data and dmux_sel <= route (below); state goes to or stays in HOLD.
- del & ~acc: HOLD -> IDLE. dmux_a and dmux_sel keep their last values, but no valid is asserted.
- While HOLD and not delivered, dmux_a and dmux_sel are stable, regardless of in_valid.
- Latency: a word accepted at edge N is presented with valid from cycle N+1. No combinational path from in_data to dmux_a.
- Tag route (mode = 0): route = in_dest. bcnt <= 0; rr_sel is unchanged.
- Alternate route (mode = 1): route = rr_sel; bcnt <= bcnt + 1.
  - When bcnt + 1 == BURST: rr_sel toggles and bcnt <= 0.
  - First burst after reset goes to branch 1.
  - Switching from mode 0 to mode 1 resumes at the current rr_sel with a full new burst.
- Counters:
  - On del: cnt1 increments if dmux_sel = 1, else cnt2 increments.
  - Saturation: hold at 2^CW - 1, no wrap.
  - cnt_clr has priority over a same-cycle increment; both go to 0.
- Ready is only sampled for the selected branch. The unselected branch's ready is ignored.
- The held word is never dropped or duplicated under arbitrary ready/valid patterns.

Test Plan:
- Reset then mode = 0: send 0xA5 with dest = 1, then 0x3C with dest = 0, readies high.
  - dmux_a = 0xA5 with sel = 1 and out1_valid for 1 cycle.
  - Then 0x3C with sel = 0 and out2_valid.
  - cnt1 = 1, cnt2 = 1; in_ready stays high.
- mode = 1, BURST = 4: stream 10 words 0x01..0x0A continuously, readies high.
  - 0x01–0x04 to branch 1, 0x05–0x08 to branch 2, 0x09–0x0A to branch 1.
  - One word per clk; cnt1 = 6, cnt2 = 4.
- Backpressure: word 0x77 to branch 2, out2_ready low for 5 cycles while in_valid stays high with 0x88.
  - dmux_a = 0x77 and sel = 0 stable; in_ready = 0 for the 5 cycles.
  - 0x88 is accepted in the cycle out2_ready rises; nothing is lost.
- Unselected ready: hold word on branch 1, toggle out2_ready, keep out1_ready = 0 -> no delivery, cnt2 unchanged.
- Counter saturation with CW = 2: deliver 5 words to branch 1 -> cnt1 = 3; then assert cnt_clr together with a delivery -> cnt1 = 0.
- Assert rst asynchronously while holding 0x5A with out1_ready = 0.
  - All outputs go to reset values immediately, with no clock edge needed.
  - After release, the first mode = 1 word goes to branch 1.

Source files
------------

// File: rtl/dmux_route_ctrl.sv
// Sequencing controller for a 1-to-2 data demultiplexer.
// Holds one word, steers it by tag or by alternating bursts.
module dmux_route_ctrl #(
   parameter int A     = 8,
   parameter int BURST = 4,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [A-1:0]  in_data,
   input  logic          in_valid,
   input  logic          in_dest,
   output logic          in_ready,
   input  logic          mode,
   input  logic          cnt_clr,
   output logic [A-1:0]  dmux_a,
   output logic          dmux_sel,
   output logic          out1_valid,
   input  logic          out1_ready,
   output logic          out2_valid,
   input  logic          out2_ready,
   output logic [CW-1:0] cnt1,
   output logic [CW-1:0] cnt2,
   output logic          busy
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [7:0]    BLEN = 8'(BURST);
   localparam logic [CW-1:0] CMAX = '1;

   state_t     state;
   state_t     state_nxt;
   logic       hold;
   logic       del;
   logic       acc;
   logic       route;
   logic       rr_sel;
   logic [7:0] bcnt;
   logic [7:0] bcnt_inc;

   assign bcnt_inc = bcnt + 8'd1;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state: a new word keeps us holding, a bare delivery empties
   always_comb begin
      state_nxt = state;
      if (acc)      state_nxt = HOLD;
      else if (del) state_nxt = IDLE;
   end

   // handshake and status outputs
   always_comb begin
      hold       = (state == HOLD);
      out1_valid = hold & dmux_sel;
      out2_valid = hold & ~dmux_sel;
      busy       = hold;
      del        = hold & (dmux_sel ? out1_ready : out2_ready);
      in_ready   = ~hold | del;
      acc        = in_valid & in_ready;
      route      = mode ? rr_sel : in_dest;
   end

   // held word and select, loaded only on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmux_a   <= '0;
         dmux_sel <= 1'b0;
      end else if (acc) begin
         dmux_a   <= in_data;
         dmux_sel <= route;
      end
   end

   // burst tracker; tag-mode words restart the burst count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_sel <= 1'b1;
         bcnt   <= 8'd0;
      end else if (acc) begin
         if (!mode) begin
            bcnt <= 8'd0;
         end else if (bcnt_inc == BLEN) begin
            bcnt   <= 8'd0;
            rr_sel <= ~rr_sel;
         end else begin
            bcnt <= bcnt_inc;
         end
      end
   end

   // saturating delivery counters, clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt1 <= '0;
         cnt2 <= '0;
      end else if (cnt_clr) begin
         cnt1 <= '0;
         cnt2 <= '0;
      end else if (del) begin
         if (dmux_sel) begin
            if (cnt1 != CMAX) cnt1 <= cnt1 + CW'(1);
         end else begin
            if (cnt2 != CMAX) cnt2 <= cnt2 + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmux_route_ctrl.sv
// Bench for dmux_route_ctrl: directed steps plus random traffic
// against a transaction-level reference model.
module tb_dmux_route_ctrl;

   localparam int A     = 8;
   localparam int BURST = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid, in_dest, mode, cnt_clr;
   logic       out1_ready, out2_ready;
   logic       in_ready, dmux_sel, out1_valid, out2_valid, busy;
   logic [7:0] dmux_a, cnt1, cnt2;
   logic       s_in_ready, s_sel, s_v1, s_v2, s_busy;
   logic [7:0] s_a;
   logic [1:0] cnt1s, cnt2s;

   int n_assert = 0;
   int n_fail   = 0;

   bit         m_hold;
   logic [7:0] m_word;
   bit         m_sel;
   int         m_c1, m_c2;
   bit         m_rr;
   int         m_k;

   always #5 clk = ~clk;

   dmux_route_ctrl #(.A(A), .BURST(BURST), .CW(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_dest(in_dest), .in_ready(in_ready), .mode(mode),
      .cnt_clr(cnt_clr), .dmux_a(dmux_a), .dmux_sel(dmux_sel),
      .out1_valid(out1_valid), .out1_ready(out1_ready),
      .out2_valid(out2_valid), .out2_ready(out2_ready),
      .cnt1(cnt1), .cnt2(cnt2), .busy(busy)
   );

   dmux_route_ctrl #(.A(A), .BURST(BURST), .CW(2)) dut_s (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_dest(in_dest), .in_ready(s_in_ready), .mode(mode),
      .cnt_clr(cnt_clr), .dmux_a(s_a), .dmux_sel(s_sel),
      .out1_valid(s_v1), .out1_ready(out1_ready),
      .out2_valid(s_v2), .out2_ready(out2_ready),
      .cnt1(cnt1s), .cnt2(cnt2s), .busy(s_busy)
   );

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = 0; m_word = 8'h00; m_sel = 0;
      m_c1 = 0; m_c2 = 0; m_rr = 1; m_k = 0;
   endtask

   task automatic check_all();
      bit del;
      del = m_hold && (m_sel ? out1_ready : out2_ready);
      check("in_ready",   32'(in_ready),   32'(!m_hold || del));
      check("dmux_a",     32'(dmux_a),     32'(m_word));
      check("dmux_sel",   32'(dmux_sel),   32'(m_sel));
      check("out1_valid", 32'(out1_valid), 32'(m_hold && m_sel));
      check("out2_valid", 32'(out2_valid), 32'(m_hold && !m_sel));
      check("busy",       32'(busy),       32'(m_hold));
      check("cnt1",       32'(cnt1),       32'(sat(m_c1, 255)));
      check("cnt2",       32'(cnt2),       32'(sat(m_c2, 255)));
      check("cnt1_cw2",   32'(cnt1s),      32'(sat(m_c1, 3)));
      check("cnt2_cw2",   32'(cnt2s),      32'(sat(m_c2, 3)));
   endtask

   // one clock edge of the transaction model, using current inputs
   task automatic model_edge();
      bit del, acc, route;
      del = m_hold && (m_sel ? out1_ready : out2_ready);
      acc = in_valid && (!m_hold || del);
      if (cnt_clr) begin
         m_c1 = 0; m_c2 = 0;
      end else if (del) begin
         if (m_sel) m_c1++;
         else       m_c2++;
      end
      if (acc) begin
         if (!mode) begin
            route = in_dest;
            m_k = 0;
         end else begin
            route = m_rr;
            m_k++;
            if (m_k == BURST) begin
               m_rr = !m_rr;
               m_k = 0;
            end
         end
         m_word = in_data; m_sel = route; m_hold = 1;
      end else if (del) begin
         m_hold = 0;
      end
   endtask

   task automatic drive(bit v, logic [7:0] d, bit dst, bit md,
                        bit r1, bit r2, bit clr);
      in_valid = v; in_data = d; in_dest = dst; mode = md;
      out1_ready = r1; out2_ready = r2; cnt_clr = clr;
   endtask

   task automatic cyc();
      #1;
      check_all();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c2_saved;
      rst = 1'b1;
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // tag mode: A5 to branch 1, 3C to branch 2
      drive(1, 8'hA5, 1, 0, 1, 1, 0); cyc();
      check("t1_a5", 32'(dmux_a), 32'h0A5);
      check("t1_v1", 32'(out1_valid), 32'd1);
      drive(1, 8'h3C, 0, 0, 1, 1, 0); cyc();
      check("t1_3c_v2", 32'(out2_valid), 32'd1);
      drive(0, 8'h00, 0, 0, 1, 1, 0); cyc();
      cyc();
      check("t1_cnt1", 32'(cnt1), 32'd1);
      check("t1_cnt2", 32'(cnt2), 32'd1);

      // alternating bursts, 10 words back to back
      drive(0, 8'h00, 0, 1, 1, 1, 1); cyc();
      for (int i = 1; i <= 10; i++) begin
         drive(1, 8'(i), 0, 1, 1, 1, 0);
         cyc();
         check("t2_word", 32'(dmux_a), 32'(i));
         check("t2_sel", 32'(dmux_sel), 32'((i <= 4) || (i >= 9)));
      end
      drive(0, 8'h00, 0, 1, 1, 1, 0); cyc();
      check("t2_cnt1", 32'(cnt1), 32'd6);
      check("t2_cnt2", 32'(cnt2), 32'd4);

      // backpressure on branch 2
      drive(1, 8'h77, 0, 0, 1, 0, 0); cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'h88, 1, 0, 1, 0, 0);
         #1;
         check("t3_stall_rdy", 32'(in_ready), 32'd0);
         check("t3_stall_a", 32'(dmux_a), 32'h77);
         cyc();
      end
      drive(1, 8'h88, 1, 0, 1, 1, 0); cyc();
      check("t3_88", 32'(dmux_a), 32'h88);
      drive(0, 8'h00, 0, 0, 1, 1, 0); cyc();

      // unselected ready must not deliver
      drive(1, 8'h42, 1, 0, 0, 0, 0); cyc();
      c2_saved = sat(m_c2, 255);
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h00, 0, 0, 0, i[0], 0);
         cyc();
      end
      check("t4_cnt2", 32'(cnt2), 32'(c2_saved));
      check("t4_held", 32'(out1_valid), 32'd1);
      drive(0, 8'h00, 0, 0, 1, 1, 0); cyc();

      // saturation on the 2-bit instance, then clear vs delivery
      drive(0, 8'h00, 0, 0, 1, 1, 1); cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'(8'h90 + i), 1, 0, 1, 1, 0);
         cyc();
      end
      drive(1, 8'hE1, 1, 0, 1, 1, 0); cyc();
      check("t5_sat", 32'(cnt1s), 32'd3);
      drive(0, 8'h00, 0, 0, 1, 1, 1); cyc();
      check("t5_clr_s", 32'(cnt1s), 32'd0);
      check("t5_clr", 32'(cnt1), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 40) == 0));
         cyc();
      end
      drive(0, 8'h00, 0, 0, 1, 1, 0); cyc();

      // asynchronous reset while holding on branch 1
      drive(1, 8'h5A, 1, 0, 0, 0, 0); cyc();
      drive(0, 8'h00, 0, 0, 0, 0, 0);
      #2;
      check("t6_pre", 32'(dmux_a), 32'h5A);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      check("t6_v1", 32'(out1_valid), 32'd0);
      check("t6_a", 32'(dmux_a), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 8'hC3, 0, 1, 1, 1, 0); cyc();
      check("t6_first_alt", 32'(dmux_sel), 32'd1);
      drive(0, 8'h00, 0, 0, 1, 1, 0); cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
